// File: rtl/squire_sense.sv
// Purpose: input conditioning for the knight quest FSM (sync, debounce, sharpness accumulator).
// Latency: a clean raw step reaches its output on the (DEBOUNCE_CYCLES+2)th rising edge.
// Backpressure: none, free-running. The stage samples its inputs on every edge and cannot stall.
//
// Ports:
//   clock, reset                 single rising-edge clock, async active-high reset
//   raw_adventure/courage/
//   raw_grindstone/dragon        asynchronous field inputs
//   adventure, courage, dragon   debounced, registered copies of the raw inputs
//   sword_sharpened              registered; high while the sharpness count is saturated
module squire_sense #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = 3,
    parameter int SHARPEN_CYCLES  = 8,
    parameter int SH_W            = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_adventure,
    input  logic raw_courage,
    input  logic raw_grindstone,
    input  logic raw_dragon,
    output logic adventure,
    output logic courage,
    output logic dragon,
    output logic sword_sharpened
);

    // Channel order in every 4-bit vector below.
    localparam int CH_ADV   = 0;
    localparam int CH_COUR  = 1;
    localparam int CH_GRIND = 2;
    localparam int CH_DRAG  = 3;
    localparam int NCH      = 4;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SH_W-1:0] SH_FULL = SH_W'(SHARPEN_CYCLES);

    logic [NCH-1:0]  raw_vec;
    logic [NCH-1:0]  sync_s1;
    logic [NCH-1:0]  sync_s2;
    logic [NCH-1:0]  db_q;
    logic [NCH-1:0]  db_next;
    logic [DB_W-1:0] db_cnt      [NCH];
    logic [DB_W-1:0] db_cnt_next [NCH];

    logic [SH_W-1:0] sharp_cnt;
    logic [SH_W-1:0] sharp_next;
    logic            grind_db;
    logic            dragon_rise;
    logic            sharpened_q;

    assign raw_vec = {raw_dragon, raw_grindstone, raw_courage, raw_adventure};

    // Two-flop synchroniser on every raw input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw_vec;
            sync_s2 <= sync_s1;
        end
    end

    // Debounce: the output follows s2 only after s2 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive edges. Any agreement restarts the count, so
    // short pulses in either direction are swallowed.
    always_comb begin
        db_next = db_q;
        for (int i = 0; i < NCH; i++) begin
            db_cnt_next[i] = db_cnt[i];
            if (sync_s2[i] == db_q[i]) begin
                db_cnt_next[i] = '0;
            end else if (db_cnt[i] == DB_LAST) begin
                db_next[i]     = sync_s2[i];
                db_cnt_next[i] = '0;
            end else begin
                db_cnt_next[i] = db_cnt[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_q <= db_next;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
        end
    end

    assign grind_db = db_q[CH_GRIND];

    // Rising edge of the debounced dragon, detected on the edge where it
    // happens, so the blade is dulled in the same cycle the dragon appears.
    assign dragon_rise = db_next[CH_DRAG] & ~db_q[CH_DRAG];

    // Sharpness: the clear wins over grinding, the count saturates at full,
    // and leaving the grindstone keeps whatever edge has been built up.
    always_comb begin
        sharp_next = sharp_cnt;
        if (dragon_rise) begin
            sharp_next = '0;
        end else if (grind_db && (sharp_cnt != SH_FULL)) begin
            sharp_next = sharp_cnt + SH_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sharp_cnt   <= '0;
            sharpened_q <= 1'b0;
        end else begin
            sharp_cnt   <= sharp_next;
            sharpened_q <= (sharp_next == SH_FULL);
        end
    end

    assign adventure       = db_q[CH_ADV];
    assign courage         = db_q[CH_COUR];
    assign dragon          = db_q[CH_DRAG];
    assign sword_sharpened = sharpened_q;

endmodule

// File: tb/tb_squire_sense.sv
// Purpose: self-checking bench for squire_sense, directed scenarios plus random traffic.
// Latency: compares every output one time unit after each rising edge.
// Backpressure: not applicable; the stimulus drives one raw vector per cycle.
module tb_squire_sense;

    localparam int D = 4;
    localparam int S = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic raw_adventure  = 1'b0;
    logic raw_courage    = 1'b0;
    logic raw_grindstone = 1'b0;
    logic raw_dragon     = 1'b0;
    logic adventure, courage, dragon, sword_sharpened;

    squire_sense dut (
        .clock           (clock),
        .reset           (reset),
        .raw_adventure   (raw_adventure),
        .raw_courage     (raw_courage),
        .raw_grindstone  (raw_grindstone),
        .raw_dragon      (raw_dragon),
        .adventure       (adventure),
        .courage         (courage),
        .dragon          (dragon),
        .sword_sharpened (sword_sharpened)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: raw samples history and the synchronised-sample history.
    // bit0 adventure, bit1 courage, bit2 grindstone, bit3 dragon.
    logic [3:0] rawq[$];
    logic [3:0] s2q[$];
    logic [3:0] m_out;
    int         m_cnt;
    logic       m_sharp;

    function automatic void model_reset();
        rawq.delete();
        s2q.delete();
        rawq.push_back(4'b0);
        rawq.push_back(4'b0);
        m_out   = 4'b0;
        m_cnt   = 0;
        m_sharp = 1'b0;
    endfunction

    // An output flips once the last D synchronised samples all disagree with it.
    function automatic void model_edge(input logic [3:0] raw);
        logic [3:0] s2now, nout, smp;
        logic       all_diff, rise;
        s2now = rawq[rawq.size()-2];
        s2q.push_back(s2now);
        rawq.push_back(raw);
        if (rawq.size() > 8) void'(rawq.pop_front());
        if (s2q.size() > 8) void'(s2q.pop_front());
        nout = m_out;
        for (int ch = 0; ch < 4; ch++) begin
            if (s2q.size() >= D) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    smp = s2q[s2q.size()-1-k];
                    if (smp[ch] == m_out[ch]) all_diff = 1'b0;
                end
                if (all_diff) nout[ch] = ~m_out[ch];
            end
        end
        rise = nout[3] & ~m_out[3];
        if (rise) m_cnt = 0;
        else if (m_out[2] && m_cnt < S) m_cnt = m_cnt + 1;
        m_out   = nout;
        m_sharp = (m_cnt == S);
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ":adventure"}, adventure, m_out[0]);
        chk({tag, ":courage"},   courage,   m_out[1]);
        chk({tag, ":dragon"},    dragon,    m_out[3]);
        chk({tag, ":sharpened"}, sword_sharpened, m_sharp);
    endtask

    // One cycle: drive inputs after the falling edge, advance the model on the
    // rising edge and compare shortly after it.
    task automatic step(input logic [3:0] r, input logic rst, input string tag);
        @(negedge clock);
        {raw_dragon, raw_grindstone, raw_courage, raw_adventure} = r;
        reset = rst;
        if (rst) model_reset();
        @(posedge clock);
        #1;
        if (rst) model_reset();
        else model_edge(r);
        compare_all(tag);
    endtask

    initial begin
        logic [3:0] rv;
        model_reset();
        #2;
        chk("reset_adventure", adventure, 1'b0);
        chk("reset_courage", courage, 1'b0);
        chk("reset_dragon", dragon, 1'b0);
        chk("reset_sharpened", sword_sharpened, 1'b0);
        step(4'b0000, 1'b1, "rst");
        step(4'b0000, 1'b1, "rst");

        // 1: courage step, visible exactly on the 6th edge.
        for (int e = 1; e <= 6; e++) begin
            step(4'b0010, 1'b0, "t1");
            chk($sformatf("t1_courage_e%0d", e), courage, (e == 6));
            chk($sformatf("t1_adventure_e%0d", e), adventure, 1'b0);
        end

        // 2: a 3-cycle dragon glitch is swallowed.
        for (int e = 1; e <= 12; e++) begin
            step((e <= 3) ? 4'b1010 : 4'b0010, 1'b0, "t2");
            chk($sformatf("t2_dragon_e%0d", e), dragon, 1'b0);
            chk($sformatf("t2_sharp_e%0d", e), sword_sharpened, 1'b0);
        end

        // 3: grindstone held 20 cycles, sharpened at edge 14, kept after release.
        for (int e = 1; e <= 30; e++) begin
            step((e <= 20) ? 4'b0110 : 4'b0010, 1'b0, "t3");
            chk($sformatf("t3_sharp_e%0d", e), sword_sharpened, (e >= 14));
        end

        // 4: dragon and grindstone together: dulled on the dragon-rise edge,
        //    sharp again 8 edges later.
        for (int e = 1; e <= 18; e++) begin
            step(4'b1110, 1'b0, "t4");
            chk($sformatf("t4_sharp_e%0d", e), sword_sharpened, (e < 6) || (e >= 14));
            chk($sformatf("t4_dragon_e%0d", e), dragon, (e >= 6));
        end

        // 5: async reset in the middle of an adventure debounce.
        step(4'b1111, 1'b0, "t5pre");
        step(4'b1111, 1'b0, "t5pre");
        step(4'b1111, 1'b0, "t5pre");
        #3;
        reset = 1'b1;
        #1;
        chk("t5_async_adventure", adventure, 1'b0);
        chk("t5_async_courage", courage, 1'b0);
        chk("t5_async_dragon", dragon, 1'b0);
        chk("t5_async_sharp", sword_sharpened, 1'b0);
        model_reset();
        step(4'b0001, 1'b1, "t5rst");
        step(4'b0001, 1'b1, "t5rst");
        for (int e = 1; e <= 8; e++) begin
            step(4'b0001, 1'b0, "t5");
            chk($sformatf("t5_adventure_e%0d", e), adventure, (e >= 6));
        end

        // 6: courage toggling every cycle never gets through; then a clean step does.
        for (int e = 1; e <= 50; e++) begin
            step((e % 2) ? 4'b0011 : 4'b0001, 1'b0, "t6tog");
            chk($sformatf("t6_tog_e%0d", e), courage, 1'b0);
        end
        for (int e = 1; e <= 6; e++) begin
            step(4'b0011, 1'b0, "t6");
            chk($sformatf("t6_courage_e%0d", e), courage, (e == 6));
        end

        // Random traffic: inputs mostly persist, bits flip occasionally,
        // plus the odd reset.
        rv = 4'b0011;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rv[b] = ~rv[b];
            end
            if ($urandom_range(0, 249) == 0) step(rv, 1'b1, "rnd_rst");
            else step(rv, 1'b0, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
